store_commit_buffer: RTL

- Sits directly downstream of the reorder buffer's store-commit port, between the ROB and the data cache.
- Accepts committed, already-masked word-aligned stores and queues them in a small in-order FIFO.
- Drains the FIFO to the data-cache memory port with a req/ack handshake.
- Tells the load/store unit when a pending store overlaps a load address, so loads do not read stale memory.

---
 rtl/store_commit_buffer_pkg.sv | 18 +
 rtl/scb_conflict_cam.sv | 27 ++
 rtl/store_commit_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/store_commit_buffer_pkg.sv
// Shared widths, depths, store mask encodings and FSM state type for the store commit buffer.
package store_commit_buffer_pkg;

  localparam int SCB_ADDR_WIDTH = 32;
  localparam int SCB_DATA_WIDTH = 32;
  localparam int SCB_DEPTH      = 4;
  localparam int SCB_PTR_WIDTH  = 2;

  localparam logic [3:0] SCB_MASK_BYTE = 4'b0001;
  localparam logic [3:0] SCB_MASK_HALF = 4'b0011;
  localparam logic [3:0] SCB_MASK_WORD = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } scb_state_e;

endpackage

// File: rtl/scb_conflict_cam.sv
// Word-address CAM across buffered stores; flags a load hitting any valid entry.
// Latency: combinational. Backpressure: none, pure lookup.
module scb_conflict_cam
  import store_commit_buffer_pkg::*;
#(
  parameter int DEPTH  = SCB_DEPTH,
  parameter int WADDR_W = SCB_ADDR_WIDTH - 2
) (
  input  logic [DEPTH-1:0]              entry_vld,
  input  logic [DEPTH-1:0][WADDR_W-1:0] entry_waddr,
  input  logic                          load_check,
  input  logic [WADDR_W-1:0]            load_waddr,
  output logic                          load_conflict
);

  logic [DEPTH-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = entry_vld[i] && (entry_waddr[i] == load_waddr);
    end
  end

  assign load_conflict = load_check && (|hit);

endmodule

// File: rtl/store_commit_buffer.sv
// In-order FIFO of committed stores drained to the dcache with req/ack; flags load/store word overlap.
// Latency: push to mem_req is 1 idle cycle. Backpressure: dcache_write_valid drops when full; pop never frees a slot same cycle.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = SCB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SCB_DATA_WIDTH,
  parameter int DEPTH      = SCB_DEPTH,
  parameter int PTR_WIDTH  = SCB_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcache_write,
  input  logic [3:0]            dcache_mask,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [DATA_WIDTH-1:0] dcache_data,
  output logic                  dcache_write_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_mask,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ack,
  input  logic                  load_check,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  load_conflict,
  output logic                  empty
);

  localparam int WADDR_W = ADDR_WIDTH - 2;
  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

  scb_state_e                       state_q, state_d;
  logic [PTR_WIDTH-1:0]             head_q, head_d, tail_q, tail_d;
  logic [PTR_WIDTH:0]               count_q, count_d;
  logic [DEPTH-1:0]                 vld_q, vld_d;
  logic [DEPTH-1:0][WADDR_W-1:0]    waddr_q, waddr_d;
  logic [DEPTH-1:0][3:0]            mask_q, mask_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic                             push, pop;
  logic                             unused_addr_bits;

  // Stores arrive word-aligned, so only the word address is kept.
  assign unused_addr_bits = ^{dcache_addr[1:0], load_addr[1:0]};

  assign dcache_write_valid = (count_q < FULL_CNT);
  assign push = dcache_write && dcache_write_valid;
  assign pop  = (state_q == S_REQ) && mem_ack;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    waddr_d = waddr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    count_d = count_q;
    state_d = state_q;

    if (push) begin
      waddr_d[tail_q] = dcache_addr[ADDR_WIDTH-1:2];
      mask_d[tail_q]  = dcache_mask;
      data_d[tail_q]  = dcache_data;
      vld_d[tail_q]   = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // S_REQ is only entered with a non-empty buffer, so pop and push never target the same slot.
    unique case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_REQ;
      S_REQ:   if (pop && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      waddr_q <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      waddr_q <= waddr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = {waddr_q[head_q], 2'b00};
  assign mem_mask = mask_q[head_q];
  assign mem_data = data_q[head_q];
  assign empty    = (count_q == '0) && (state_q == S_IDLE);

  scb_conflict_cam #(
    .DEPTH   (DEPTH),
    .WADDR_W (WADDR_W)
  ) u_cam (
    .entry_vld     (vld_q),
    .entry_waddr   (waddr_q),
    .load_check    (load_check),
    .load_waddr    (load_addr[ADDR_WIDTH-1:2]),
    .load_conflict (load_conflict)
  );

endmodule
